bsg_link_sdr_reset_sequencer: RTL and testbench
===============================================

# bsg_link_sdr_reset_sequencer

Generates the ordered reset sequence for a pair of fwd/rev SDR links on an IO router tile. The four outputs drive the tile's `async_*_reset` inputs and are daisy-chained to neighbouring tiles:

- token reset pulse
- then uplink release
- then downlink release
- then downstream release

Every phase holds for a programmable number of cycles. The block runs in the link-control clock domain, with one sequencer per IO column. Software or the bring-up FSM triggers a run and waits for `done_o`.

## Interface
- `wait_width_p`, default 8: width of the per-phase hold count.
- `auto_start_p`, default 0: 1 = start a sequence automatically after `core_reset_n_i` deasserts.
- `core_clk_i`, input, 1: sequencer clock. All outputs are registered on its rising edge.
- `core_reset_n_i`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: request a sequence. Sampled only in IDLE or DONE.
- `wait_cycles_i`, input, `wait_width_p`: hold count W. Latched at sequence start.
- `async_uplink_reset_o`, output, 1: uplink reset. Active-high, glitch-free (flop output).
- `async_downlink_reset_o`, output, 1: downlink reset. Active-high, flop output.
- `async_downstream_reset_o`, output, 1: downstream reset. Active-high, flop output.
- `async_token_reset_o`, output, 1: token reset. Active-high, flop output.
- `busy_o`, output, 1: a sequence is in progress.
- `done_o`, output, 1: the last sequence completed. Links are live.

## Operation
- **States:** IDLE, ASSERT, TOKEN_SET, TOKEN_CLR, UP_REL, DOWN_REL, DS_REL, DONE.
- **Outputs per state** (listed as uplink / downlink / downstream / token):
  - IDLE: 1 / 1 / 1 / 0
  - ASSERT: 1 / 1 / 1 / 0
  - TOKEN_SET: 1 / 1 / 1 / 1
  - TOKEN_CLR: 1 / 1 / 1 / 0
  - UP_REL: 0 / 1 / 1 / 0
  - DOWN_REL: 0 / 0 / 1 / 0
  - DS_REL: 0 / 0 / 0 / 0
  - DONE: 0 / 0 / 0 / 0
- **Starting a sequence:**
  - IDLE or DONE with `start_i` = 1 → ASSERT.
  - At the same edge, latch `wait_r` = `wait_cycles_i` and load the phase counter with `wait_cycles_i`.
- **Phase stepping:**
  - Each of ASSERT…DS_REL holds for exactly W+1 cycles. The counter decrements every cycle.
  - When the counter reads 0, advance to the next state and reload the counter from `wait_r`.
  - DS_REL is followed by DONE.
- **Holding states:**
  - DONE holds until `start_i` = 1.
  - A restart from DONE re-enters ASSERT, which re-asserts uplink, downlink and downstream on the next edge.
- **Busy window:** `start_i` is ignored while `busy_o` = 1. A running sequence is never restarted or truncated.
- **Status flags:**
  - `busy_o` = 1 in ASSERT…DS_REL.
  - `done_o` = 1 only in DONE.
- **Auto start:** with `auto_start_p` = 1, the first edge after reset release behaves as if `start_i` = 1 in IDLE.
- **Output encoding:** outputs are a registered decode of next-state, so each output changes on the same edge the state changes. No combinational path goes from any input to any output.
- **Reset:**
  - Asserting `core_reset_n_i` at any time forces the IDLE values immediately (asynchronous): uplink/downlink/downstream = 1, token = 0, `busy_o` = 0, `done_o` = 0.
  - A partially released link is re-reset.

## Timing
- Cycle numbering: `start_i` is sampled at edge 0, so ASSERT is visible from cycle 1. Let P = W+1.
- Output changes:
  - `async_token_reset_o` = 1 during cycles [1+P, 1+2P).
  - Uplink releases at 1+3P.
  - Downlink releases at 1+4P.
  - Downstream releases at 1+5P.
  - `done_o` rises at 1+6P.
- W = 0 gives a minimum of 1 cycle per phase. Total latency from `start_i` to `done_o` is 6P+1 cycles.
- W = 2^`wait_width_p` − 1 is legal. The counter never wraps mid-phase.
- Changes to `wait_cycles_i` during a sequence have no effect until the next start.
- `start_i` asserted on the same cycle `core_reset_n_i` deasserts is ignored, because reset recovery is assumed on that edge. `start_i` is sampled from the following edge.

## Test plan
- **Minimum hold:** W = 0, pulse `start_i` at cycle 0.
  - Token high only in cycle 2.
  - Uplink low from cycle 4, downlink from 5, downstream from 6.
  - `done_o` = 1 at cycle 7; `busy_o` = 1 in cycles 1–6.
- **Longer hold:** W = 3. Check each transition at 1+kP with P = 4. `done_o` rises at cycle 25.
- **Start/wait ignored while busy:** with W = 3, pulse `start_i` at cycles 5 and 10 and change `wait_cycles_i` to 9 mid-run.
  - Timing is identical to the previous scenario. No extra sequence runs.
- **Restart from DONE:** after completion, pulse `start_i`.
  - Uplink/downlink/downstream = 1 on the next cycle, `done_o` drops, `busy_o` = 1.
  - The full sequence repeats.
- **Reset mid-sequence:** drop `core_reset_n_i` asynchronously during UP_REL (between edges).
  - Outputs return to 1/1/1/0 immediately, before the next edge, with `busy_o` = 0 and `done_o` = 0.
  - After release with `auto_start_p` = 0, the block stays in IDLE.
- **Auto start:** `auto_start_p` = 1, W = 1. Release reset with no `start_i`.
  - ASSERT begins on the first edge after release.
  - `done_o` follows 13 cycles after that edge.

Source files
------------

// File: rtl/bsg_link_sdr_reset_sequencer_if.sv
// Control/status bundle for the SDR link reset sequencer: trigger, hold count,
// and the four daisy-chained link resets plus busy/done status.
interface bsg_link_sdr_reset_sequencer_if #(
  parameter int wait_width_p = 8
);
  logic                    start_i;
  logic [wait_width_p-1:0] wait_cycles_i;
  logic                    async_uplink_reset_o;
  logic                    async_downlink_reset_o;
  logic                    async_downstream_reset_o;
  logic                    async_token_reset_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, wait_cycles_i,
    input  async_uplink_reset_o, async_downlink_reset_o,
           async_downstream_reset_o, async_token_reset_o, busy_o, done_o
  );

  modport slave (
    input  start_i, wait_cycles_i,
    output async_uplink_reset_o, async_downlink_reset_o,
           async_downstream_reset_o, async_token_reset_o, busy_o, done_o
  );
endinterface

// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Ordered reset sequencer for a fwd/rev SDR link pair: token pulse, then
// uplink, downlink and downstream release, each phase held W+1 cycles.
module bsg_link_sdr_reset_sequencer #(
  parameter int wait_width_p = 8,
  parameter bit auto_start_p = 1'b0
) (
  input  logic                                  core_clk_i,
  input  logic                                  core_reset_n_i,
  bsg_link_sdr_reset_sequencer_if.slave         ctl
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ASSERT    = 3'd1,
    S_TOKEN_SET = 3'd2,
    S_TOKEN_CLR = 3'd3,
    S_UP_REL    = 3'd4,
    S_DOWN_REL  = 3'd5,
    S_DS_REL    = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  localparam logic [wait_width_p-1:0] CNT_ONE = 1;

  state_e                  state_q, state_d;
  logic [wait_width_p-1:0] cnt_q, cnt_d;
  logic [wait_width_p-1:0] wait_q, wait_d;
  logic                    rdy_q;
  logic                    up_q, dn_q, ds_q, tok_q, busy_q, done_q;
  logic                    run_q;
  logic                    start_go;

  // First edge after reset is the recovery edge: start_i is not sampled
  // there, but auto-start (if enabled) fires on it.
  assign run_q    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign start_go = rdy_q ? (ctl.start_i && !run_q) : auto_start_p;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    if (start_go) begin
      state_d = S_ASSERT;
      cnt_d   = ctl.wait_cycles_i;
      wait_d  = ctl.wait_cycles_i;
    end else if (run_q) begin
      // busy states are consecutive encodings; DS_REL + 1 is DONE
      if (cnt_q == '0) begin
        state_d = state_e'(state_q + 3'd1);
        cnt_d   = wait_q;
      end else begin
        cnt_d   = cnt_q - CNT_ONE;
      end
    end
  end

  // Outputs decode next-state so they flip on the same edge as the state.
  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      rdy_q   <= 1'b0;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      ds_q    <= 1'b1;
      tok_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rdy_q   <= 1'b1;
      up_q    <= state_d inside {S_IDLE, S_ASSERT, S_TOKEN_SET, S_TOKEN_CLR};
      dn_q    <= state_d inside {S_IDLE, S_ASSERT, S_TOKEN_SET, S_TOKEN_CLR, S_UP_REL};
      ds_q    <= state_d inside {S_IDLE, S_ASSERT, S_TOKEN_SET, S_TOKEN_CLR, S_UP_REL,
                                 S_DOWN_REL};
      tok_q   <= (state_d == S_TOKEN_SET);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign ctl.async_uplink_reset_o     = up_q;
  assign ctl.async_downlink_reset_o   = dn_q;
  assign ctl.async_downstream_reset_o = ds_q;
  assign ctl.async_token_reset_o      = tok_q;
  assign ctl.busy_o                   = busy_q;
  assign ctl.done_o                   = done_q;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Bench for the link reset sequencer: table of sequence scenarios checked
// cycle by cycle against a timing model, plus reset and auto-start cases.
module tb_bsg_link_sdr_reset_sequencer;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bsg_link_sdr_reset_sequencer_if #(.wait_width_p(8)) c0 ();
  bsg_link_sdr_reset_sequencer_if #(.wait_width_p(8)) c1 ();

  bsg_link_sdr_reset_sequencer #(.wait_width_p(8), .auto_start_p(1'b0)) dut0 (
    .core_clk_i(clk), .core_reset_n_i(rst0_n), .ctl(c0)
  );
  bsg_link_sdr_reset_sequencer #(.wait_width_p(8), .auto_start_p(1'b1)) dut1 (
    .core_clk_i(clk), .core_reset_n_i(rst1_n), .ctl(c1)
  );

  typedef struct {
    int    w;
    int    p1;
    int    p2;
    int    wmid;
    int    exp_done;
    string nm;
  } vec_t;

  logic [5:0] sb_q[$];

  // {uplink, downlink, downstream, token, busy, done} for cycle k after start edge
  function automatic logic [5:0] exp_vec(input int k, input int p);
    int ph;
    ph = (k - 1) / p;
    return {ph < 3, ph < 4, ph < 5, ph == 1, ph < 6, ph >= 6};
  endfunction

  function automatic logic [5:0] act(input int sel);
    if (sel == 0)
      return {c0.async_uplink_reset_o, c0.async_downlink_reset_o,
              c0.async_downstream_reset_o, c0.async_token_reset_o, c0.busy_o, c0.done_o};
    return {c1.async_uplink_reset_o, c1.async_downlink_reset_o,
            c1.async_downstream_reset_o, c1.async_token_reset_o, c1.busy_o, c1.done_o};
  endfunction

  task automatic check(input string nm, input logic [5:0] a, input logic [5:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got up/dn/ds/tok/busy/done=%b want %b", nm, a, e);
    end
  endtask

  // Called at a negedge; the sequence start is sampled on the next posedge.
  task automatic run_seq(input int sel, input vec_t v);
    int p;
    int done_at;
    logic [5:0] e;
    logic [5:0] a;
    p = v.w + 1;
    done_at = -1;
    if (sel == 0) begin
      c0.start_i = 1'b1;
      c0.wait_cycles_i = 8'(v.w);
    end else begin
      c1.wait_cycles_i = 8'(v.w);
    end
    for (int cyc = 1; cyc <= 6 * p + 3; cyc++) begin
      @(posedge clk);
      #1;
      if (sel == 0) begin
        c0.start_i = (cyc == v.p1) || (cyc == v.p2);
        if (cyc == 4) c0.wait_cycles_i = 8'(v.wmid);
      end
      sb_q.push_back(exp_vec(cyc, p));
      @(negedge clk);
      a = act(sel);
      e = sb_q.pop_front();
      check($sformatf("%s cyc%0d", v.nm, cyc), a, e);
      if (a[0] && done_at < 0) done_at = cyc;
    end
    checks++;
    if (done_at != v.exp_done) begin
      errors++;
      $display("FAIL %s done_rise: got cycle %0d want %0d", v.nm, done_at, v.exp_done);
    end
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{w: 0,   p1: 0, p2: 0,  wmid: 0,   exp_done: 7,    nm: "min_hold"};
    tbl[1] = '{w: 3,   p1: 0, p2: 0,  wmid: 3,   exp_done: 25,   nm: "hold3_restart"};
    tbl[2] = '{w: 3,   p1: 5, p2: 10, wmid: 9,   exp_done: 25,   nm: "busy_ignore"};
    tbl[3] = '{w: 1,   p1: 0, p2: 0,  wmid: 1,   exp_done: 13,   nm: "hold1"};
    tbl[4] = '{w: 255, p1: 0, p2: 0,  wmid: 255, exp_done: 1537, nm: "max_hold"};

    c0.start_i = 1'b0;
    c0.wait_cycles_i = 8'd0;
    c1.start_i = 1'b0;
    c1.wait_cycles_i = 8'd1;

    #23;
    check("reset0", act(0), 6'b111000);
    check("reset1", act(1), 6'b111000);

    // start_i on the reset-release cycle must be ignored
    @(negedge clk);
    rst0_n = 1'b1;
    c0.start_i = 1'b1;
    @(posedge clk);
    #1 c0.start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("release_start_ignored%0d", i), act(0), 6'b111000);
    end

    // first run from IDLE, the rest restart from DONE
    for (int i = 0; i < 5; i++) run_seq(0, tbl[i]);

    // asynchronous reset in UP_REL
    c0.start_i = 1'b1;
    c0.wait_cycles_i = 8'd3;
    @(posedge clk);
    #1 c0.start_i = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("pre_reset_uprel", act(0), exp_vec(14, 4));
    #2 rst0_n = 1'b0;
    #1 check("async_reset_immediate", act(0), 6'b111000);
    @(negedge clk);
    rst0_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stay_idle%0d", i), act(0), 6'b111000);
    end

    // auto start: release dut1 with start_i low
    check("auto_held_in_reset", act(1), 6'b111000);
    rst1_n = 1'b1;
    run_seq(1, '{w: 1, p1: 0, p2: 0, wmid: 1, exp_done: 13, nm: "auto_start"});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
